// File: rtl/bram_lanes.sv
// bram_lanes: lane-writable simple-dual-port BRAM with clear sequencer; `define BRAM_LANES_WR_BYPASS_EN for write-first forwarding
module bram_lanes #(
  parameter int DATA_W = 24,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 10,
  parameter int INIT_ZERO = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/LANE_W-1:0] wr_be,
  input  logic                     clr_req,
  output logic                     busy
);
  localparam int LANES = DATA_W / LANE_W;
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d;
  logic idle, rd_ok;
  logic [LANES-1:0] mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, rd_word;
  assign idle = state_q == IDLE;
  assign rd_ok = idle && rd_en;
  assign busy = !idle;
  assign rd_valid = rd_valid_q;
  always_comb begin
    state_d = idle ? (clr_req ? CLEAR : IDLE) : (&cnt_q ? IDLE : CLEAR);
    cnt_d = idle ? cnt_q : cnt_q + ADDR_W'(1);
    rd_valid_d = rd_ok;
    rd_data_d = rd_ok ? rd_word : rd_data_q;
    mem_we = idle ? (wr_en ? wr_be : '0) : '1;
    mem_addr = idle ? wr_addr : cnt_q;
    mem_wdata = idle ? wr_data : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  if (INIT_ZERO != 0) begin : g_mem
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
    always_ff @(posedge clk)
      for (int i = 0; i < LANES; i++)
        if (mem_we[i]) mem[mem_addr][i*LANE_W +: LANE_W] <= mem_wdata[i*LANE_W +: LANE_W];
    assign rd_word = mem[rd_addr];
  end else begin : g_mem
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
      for (int i = 0; i < LANES; i++)
        if (mem_we[i]) mem[mem_addr][i*LANE_W +: LANE_W] <= mem_wdata[i*LANE_W +: LANE_W];
    assign rd_word = mem[rd_addr];
  end
`ifdef BRAM_LANES_WR_BYPASS_EN
  logic [LANES-1:0] byp_q, byp_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d;
  always_comb begin
    byp_d = rd_ok ? ((wr_en && wr_addr == rd_addr) ? wr_be : '0) : byp_q;
    byp_data_d = rd_ok ? wr_data : byp_data_q;
    rd_data = rd_data_q;
    for (int i = 0; i < LANES; i++)
      rd_data[i*LANE_W +: LANE_W] = byp_q[i] ? byp_data_q[i*LANE_W +: LANE_W] : rd_data_q[i*LANE_W +: LANE_W];
  end
  always_ff @(posedge clk) begin
    byp_q <= rst ? '0 : byp_d;
    byp_data_q <= byp_data_d;
  end
`else
  assign rd_data = rd_data_q;
`endif
endmodule

// File: tb/tb_bram_lanes.sv
// tb_bram_lanes: randomized bench for bram_lanes against a word/lane array model
module tb_bram_lanes;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0, rd_en = 1'b0, wr_en = 1'b0, clr_req = 1'b0;
  logic [9:0] rd_addr = '0, wr_addr = '0;
  logic [23:0] wr_data = '0, rd_data;
  logic [2:0] wr_be = '0;
  logic rd_valid, busy;
  logic s_rd_en = 1'b0, s_wr_en = 1'b0, s_clr = 1'b0;
  logic [3:0] s_rd_addr = '0, s_wr_addr = '0, s_wr_be = '0;
  logic [31:0] s_wr_data = '0, s_rd_data;
  logic s_rd_valid, s_busy;
  int passed = 0, total = 0;
  bit started = 1'b0;
  logic [23:0] mm [1024];
  logic [2:0] mk [1024] = '{default: 3'b000};
  logic [23:0] e_data = '0;
  logic [2:0] e_known = 3'b111;
  logic e_valid = 1'b0;
  int clr_left = 0, clr_addr = 0;

  bram_lanes u_dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .clr_req(clr_req), .busy(busy)
  );
  bram_lanes #(.DATA_W(32), .LANE_W(8), .ADDR_W(4)) u_small (
    .clk(clk), .rst(rst), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_be(s_wr_be), .clr_req(s_clr), .busy(s_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [23:0] lane_bits(input logic [2:0] k);
    logic [23:0] r;
    for (int i = 0; i < 3; i++) r[i*8 +: 8] = {8{k[i]}};
    return r;
  endfunction

  always @(posedge clk) begin : model
    if (rst) begin
      if (clr_left > 0) mk[clr_addr] = 3'b000;
      e_data = '0;
      e_known = 3'b111;
      e_valid = 1'b0;
      clr_left = 0;
      clr_addr = 0;
      started = 1'b1;
    end else if (clr_left > 0) begin
      mm[clr_addr] = '0;
      mk[clr_addr] = 3'b111;
      clr_addr++;
      clr_left--;
      e_valid = 1'b0;
    end else begin
      e_valid = rd_en;
      if (rd_en) begin
        e_data = mm[rd_addr];
        e_known = mk[rd_addr];
`ifdef BRAM_LANES_WR_BYPASS_EN
        if (wr_en && wr_addr == rd_addr)
          for (int i = 0; i < 3; i++)
            if (wr_be[i]) begin
              e_data[i*8 +: 8] = wr_data[i*8 +: 8];
              e_known[i] = 1'b1;
            end
`endif
      end
      if (wr_en)
        for (int i = 0; i < 3; i++)
          if (wr_be[i]) begin
            mm[wr_addr][i*8 +: 8] = wr_data[i*8 +: 8];
            mk[wr_addr][i] = 1'b1;
          end
      if (clr_req) begin
        clr_left = 1024;
        clr_addr = 0;
      end
    end
    #2;
    if (started) begin
      check("busy", 32'(busy), 32'(clr_left > 0));
      check("rd_valid", 32'(rd_valid), 32'(e_valid));
      check("rd_data", 32'(rd_data & lane_bits(e_known)), 32'(e_data & lane_bits(e_known)));
    end
  end

  task automatic cyc(input int re, input int ra, input int we, input int wa, input int wd, input int be, input int cr, input int r);
    rd_en = re[0];
    rd_addr = 10'(ra);
    wr_en = we[0];
    wr_addr = 10'(wa);
    wr_data = 24'(wd);
    wr_be = 3'(be);
    clr_req = cr[0];
    rst = r[0];
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int n;
    int ra, wa;
    bit r;
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    check("reset rd_data", 32'(rd_data), 32'h0);
    check("reset rd_valid", 32'(rd_valid), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    cyc(0, 0, 1, 5, 24'hA1B2C3, 7, 0, 0);
    cyc(1, 5, 0, 0, 0, 0, 0, 0);
    check("read addr5", 32'(rd_data), 32'hA1B2C3);
    check("read addr5 valid", 32'(rd_valid), 32'h1);
    idle();
    check("idle valid", 32'(rd_valid), 32'h0);
    check("idle hold", 32'(rd_data), 32'hA1B2C3);
    cyc(0, 0, 1, 7, 24'h112233, 7, 0, 0);
    cyc(0, 0, 1, 7, 24'hFFEEDD, 2, 0, 0);
    cyc(0, 0, 1, 7, 24'h000000, 0, 0, 0);
    cyc(1, 7, 0, 0, 0, 0, 0, 0);
    check("lane mask", 32'(rd_data), 32'h11EE33);
    cyc(0, 0, 1, 9, 24'h000001, 7, 0, 0);
    cyc(1, 9, 1, 9, 24'h0000FF, 7, 0, 0);
`ifdef BRAM_LANES_WR_BYPASS_EN
    check("rdw same addr", 32'(rd_data), 32'h0000FF);
`else
    check("rdw same addr", 32'(rd_data), 32'h000001);
`endif
    cyc(1, 9, 0, 0, 0, 0, 0, 0);
    check("after rdw", 32'(rd_data), 32'h0000FF);
    idle();
    s_wr_en = 1'b1; s_wr_addr = 4'd3; s_wr_data = 32'hDEADBEEF; s_wr_be = 4'hF;
    @(negedge clk);
    s_wr_data = 32'h11223344; s_wr_be = 4'b1000;
    @(negedge clk);
    s_wr_en = 1'b0; s_rd_en = 1'b1; s_rd_addr = 4'd3;
    @(negedge clk);
    check("small be1000", s_rd_data, 32'h11ADBEEF);
    check("small valid", 32'(s_rd_valid), 32'h1);
    s_rd_en = 1'b0; s_clr = 1'b1;
    @(negedge clk);
    s_clr = 1'b0;
    n = 0;
    while (s_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("small clear cycles", 32'(n), 32'd16);
    s_rd_en = 1'b1;
    @(negedge clk);
    s_rd_en = 1'b0;
    check("small cleared", s_rd_data, 32'h0);
    for (int a = 0; a < 4; a++) cyc(0, 0, 1, a, 24'h5A0000 + a + 1, 7, 0, 0);
    cyc(1, 5, 0, 0, 0, 0, 1, 0);
    check("read with clr_req", 32'(rd_data), 32'hA1B2C3);
    check("busy rises", 32'(busy), 32'h1);
    n = 1;
    while (busy && n < 2000) begin
      cyc(int'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 1023)), int'($urandom_range(0, 24'hFFFFFF)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 63) == 0), 0);
      if (busy) n++;
    end
    check("clear cycles", 32'(n), 32'd1024);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("cleared addr0", 32'(rd_data), 32'h0);
    cyc(1, 3, 0, 0, 0, 0, 0, 0);
    check("cleared addr3", 32'(rd_data), 32'h0);
    cyc(1, 1023, 0, 0, 0, 0, 0, 0);
    check("cleared addr1023", 32'(rd_data), 32'h0);
    cyc(0, 0, 1, 1000, 24'h123456, 7, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k < 10; k++) idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    check("abort busy", 32'(busy), 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("abort addr0", 32'(rd_data), 32'h0);
    cyc(1, 1000, 0, 0, 0, 0, 0, 0);
    check("abort addr1000", 32'(rd_data), 32'h123456);
    for (int k = 0; k < 5000; k++) begin
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 15));
      wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 15));
      r = $urandom_range(0, 1999) == 0;
      if (r) cyc(0, 0, 0, 0, 0, 0, 0, 1);
      else cyc(int'($urandom_range(0, 1)), ra, int'($urandom_range(0, 1)), wa,
               int'($urandom_range(0, 24'hFFFFFF)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 1499) == 0), 0);
    end
    idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
